wfq_vt_event_tracker: RTL and testbench

- Producer side of the virtual-time update interface: drives `start`, `delta_t` and `sum_weight` into the `virtual_time` block.
- Tracks per-flow backlog from arrival and departure events and the real-time cycles elapsed between events.
- On each valid event, issues one update describing the interval that just closed: its length and the summed weight of flows backlogged during it.
- Sits between the packet classifier/queue manager and `virtual_time` in the WFQ computation path.

---
 rtl/wfq_vt_event_tracker.sv | 133 +++++++++++++
 tb/tb_wfq_vt_event_tracker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wfq_vt_event_tracker.sv
// Producer for the WFQ virtual-time update: tracks per-flow backlog and elapsed cycles,
// and on each arrival/departure event reports the closed interval's length and backlogged weight.
module wfq_vt_event_tracker #(
  parameter int NUM_FLOWS = 4,
  parameter int FLOW_W    = 2,
  parameter int WGT_W     = 16,
  parameter int QD_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [FLOW_W-1:0]    cfg_flow,
  input  logic [WGT_W-1:0]     cfg_weight,
  input  logic                 arr_valid,
  input  logic [FLOW_W-1:0]    arr_flow,
  input  logic                 dep_valid,
  input  logic [FLOW_W-1:0]    dep_flow,
  output logic                 start,
  output logic [WGT_W-1:0]     delta_t,
  output logic [WGT_W-1:0]     sum_weight,
  output logic [NUM_FLOWS-1:0] active_mask,
  output logic                 dep_err
);

  localparam int SUM_W = WGT_W + FLOW_W;

  logic [WGT_W-1:0]     weight_cur  [NUM_FLOWS];
  logic [QD_W-1:0]      backlog_cur [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] active_next;

  logic [WGT_W-1:0]     elapsed_reg;
  logic [WGT_W-1:0]     elapsed_inc;
  logic                 start_reg;
  logic                 dep_err_reg;
  logic [WGT_W-1:0]     delta_t_reg;
  logic [WGT_W-1:0]     sum_weight_reg;
  logic [NUM_FLOWS-1:0] active_mask_reg;

  logic                 dep_ok;
  logic                 event_valid;
  logic [SUM_W-1:0]     sum_pre;
  logic [WGT_W-1:0]     sum_sat;

  // A departure only counts when the flow actually holds a packet.
  assign dep_ok      = dep_valid && (backlog_cur[dep_flow] != '0);
  assign event_valid = arr_valid || dep_ok;
  assign elapsed_inc = (elapsed_reg == '1) ? elapsed_reg : elapsed_reg + WGT_W'(1);

  always_comb begin
    sum_pre = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      if (backlog_cur[i] != '0) begin
        sum_pre = sum_pre + SUM_W'(weight_cur[i]);
      end
    end
  end

  assign sum_sat = (|sum_pre[SUM_W-1:WGT_W]) ? '1 : sum_pre[WGT_W-1:0];

  for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
    localparam logic [FLOW_W-1:0] IDX = FLOW_W'(gi);

    logic [QD_W-1:0]  backlog_reg;
    logic [QD_W-1:0]  backlog_next;
    logic [WGT_W-1:0] weight_reg;
    logic             inc;
    logic             dec;

    assign inc = arr_valid && (arr_flow == IDX);
    assign dec = dep_ok && (dep_flow == IDX);

    // Arrival and departure on the same flow cancel, even at the saturation ceiling.
    always_comb begin
      backlog_next = backlog_reg;
      if (inc && !dec) begin
        if (backlog_reg != '1) begin
          backlog_next = backlog_reg + QD_W'(1);
        end
      end else if (dec && !inc) begin
        backlog_next = backlog_reg - QD_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        backlog_reg <= '0;
        weight_reg  <= '0;
      end else begin
        backlog_reg <= backlog_next;
        if (cfg_we && (cfg_flow == IDX)) begin
          weight_reg <= cfg_weight;
        end
      end
    end

    assign backlog_cur[gi] = backlog_reg;
    assign weight_cur[gi]  = weight_reg;
    assign active_next[gi] = (backlog_next != '0);
  end

  // An idle interval (no weight backlogged) closes silently: no update, outputs hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elapsed_reg     <= '0;
      start_reg       <= 1'b0;
      dep_err_reg     <= 1'b0;
      delta_t_reg     <= '0;
      sum_weight_reg  <= '0;
      active_mask_reg <= '0;
    end else begin
      dep_err_reg     <= dep_valid && !dep_ok;
      active_mask_reg <= active_next;
      start_reg       <= 1'b0;
      if (event_valid) begin
        elapsed_reg <= '0;
        if (sum_pre != '0) begin
          start_reg      <= 1'b1;
          delta_t_reg    <= elapsed_inc;
          sum_weight_reg <= sum_sat;
        end
      end else begin
        elapsed_reg <= elapsed_inc;
      end
    end
  end

  assign start       = start_reg;
  assign delta_t     = delta_t_reg;
  assign sum_weight  = sum_weight_reg;
  assign active_mask = active_mask_reg;
  assign dep_err     = dep_err_reg;

endmodule

// File: tb/tb_wfq_vt_event_tracker.sv
// Bench for wfq_vt_event_tracker: directed scenarios plus random traffic against an
// integer-arithmetic reference model of the interval/backlog rules.
module tb_wfq_vt_event_tracker;
  localparam int NF   = 4;
  localparam int FW   = 2;
  localparam int WW   = 16;
  localparam int QW   = 8;
  localparam int WMAX = (1 << WW) - 1;
  localparam int QMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [FW-1:0] cfg_flow = '0;
  logic [WW-1:0] cfg_weight = '0;
  logic          arr_valid = 1'b0;
  logic [FW-1:0] arr_flow = '0;
  logic          dep_valid = 1'b0;
  logic [FW-1:0] dep_flow = '0;
  logic          start;
  logic [WW-1:0] delta_t;
  logic [WW-1:0] sum_weight;
  logic [NF-1:0] active_mask;
  logic          dep_err;

  always #5 clk = ~clk;

  wfq_vt_event_tracker #(.NUM_FLOWS(NF), .FLOW_W(FW), .WGT_W(WW), .QD_W(QW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_weight(cfg_weight),
    .arr_valid(arr_valid), .arr_flow(arr_flow),
    .dep_valid(dep_valid), .dep_flow(dep_flow),
    .start(start), .delta_t(delta_t), .sum_weight(sum_weight),
    .active_mask(active_mask), .dep_err(dep_err)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  // Reference model state
  int m_weight [NF];
  int m_backlog[NF];
  int m_e;
  int m_delta;
  int m_sum;
  bit m_start;
  bit m_dep_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < NF; i++) if (m_backlog[i] > 0) m |= (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_weight[i]  = 0;
      m_backlog[i] = 0;
    end
    m_e = 0; m_delta = 0; m_sum = 0; m_start = 0; m_dep_err = 0;
  endtask

  task automatic model_clock();
    int s;
    bit dep_ok;
    bit ev;
    if (!rst) begin
      model_reset();
      return;
    end
    s = 0;
    for (int i = 0; i < NF; i++) if (m_backlog[i] > 0) s += m_weight[i];
    dep_ok    = dep_valid && (m_backlog[dep_flow] > 0);
    ev        = arr_valid || dep_ok;
    m_dep_err = dep_valid && !dep_ok;
    m_start   = 0;
    if (ev) begin
      if (s != 0) begin
        m_start = 1;
        m_delta = sat(m_e + 1, WMAX);
        m_sum   = sat(s, WMAX);
      end
      m_e = 0;
    end else begin
      m_e = sat(m_e + 1, WMAX);
    end
    if (!(arr_valid && dep_ok && arr_flow == dep_flow)) begin
      if (arr_valid) m_backlog[arr_flow] = sat(m_backlog[arr_flow] + 1, QMAX);
      if (dep_ok)    m_backlog[dep_flow] = m_backlog[dep_flow] - 1;
    end
    if (cfg_we) m_weight[cfg_flow] = int'(cfg_weight);
  endtask

  task automatic compare_all();
    check("start", start, m_start);
    check("delta_t", delta_t, m_delta);
    check("sum_weight", sum_weight, m_sum);
    check("active_mask", active_mask, model_mask());
    check("dep_err", dep_err, m_dep_err);
  endtask

  task automatic step(input bit do_check);
    @(posedge clk);
    model_clock();
    #1;
    if (do_check) begin
      compare_all();
      if (m_start || m_dep_err)
        $display("txn %s: start=%0d delta_t=%0h sum_weight=%0h active_mask=%0h dep_err=%0d",
                 phase, start, delta_t, sum_weight, active_mask, dep_err);
    end
  endtask

  task automatic set_idle();
    cfg_we = 0; arr_valid = 0; dep_valid = 0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) step(1);
  endtask

  task automatic do_arr(input int f);
    set_idle(); arr_valid = 1; arr_flow = FW'(f);
    step(1); set_idle();
  endtask

  task automatic do_dep(input int f);
    set_idle(); dep_valid = 1; dep_flow = FW'(f);
    step(1); set_idle();
  endtask

  task automatic wr_w(input int f, input int w);
    set_idle(); cfg_we = 1; cfg_flow = FW'(f); cfg_weight = WW'(w);
    step(1); set_idle();
  endtask

  task automatic randomize_inputs(input int pct_arr, input int pct_dep, input int pct_cfg);
    arr_valid  = ($urandom_range(0, 99) < pct_arr);
    arr_flow   = FW'($urandom_range(0, NF - 1));
    dep_valid  = ($urandom_range(0, 99) < pct_dep);
    dep_flow   = FW'($urandom_range(0, NF - 1));
    cfg_we     = ($urandom_range(0, 99) < pct_cfg);
    cfg_flow   = FW'($urandom_range(0, NF - 1));
    cfg_weight = ($urandom_range(0, 7) == 0) ? '0 : WW'($urandom_range(0, WMAX));
  endtask

  initial begin
    model_reset();

    // Reset held with random inputs: everything stays zero
    phase = "reset_hold";
    for (int i = 0; i < 5; i++) begin
      randomize_inputs(50, 50, 50);
      step(1);
    end
    set_idle();
    rst = 1'b1;
    phase = "post_reset_idle";
    idle(10);
    check("idle_start", start, 0);
    check("idle_mask", active_mask, 0);

    // Basic interval reporting
    phase = "basic";
    wr_w(0, 'h4000); wr_w(1, 'h8000); wr_w(2, 'h2000); wr_w(3, 'h2000);
    idle(2);
    do_arr(0);
    check("first_arr_start", start, 0);
    check("first_arr_mask", active_mask, 'b0001);
    idle(2);
    do_arr(1);
    check("arr_f1_start", start, 1);
    check("arr_f1_delta", delta_t, 3);
    check("arr_f1_sum", sum_weight, 'h4000);
    check("arr_f1_mask", active_mask, 'b0011);
    set_idle(); dep_valid = 1; dep_flow = 0; arr_valid = 1; arr_flow = 2;
    step(1); set_idle();
    check("depf0_arrf2_delta", delta_t, 1);
    check("depf0_arrf2_sum", sum_weight, 'hC000);
    check("depf0_arrf2_mask", active_mask, 'b0110);
    idle(4);
    do_dep(1);
    check("dep_f1_start", start, 1);
    check("dep_f1_delta", delta_t, 5);
    check("dep_f1_sum", sum_weight, 'hA000);
    check("dep_f1_mask", active_mask, 'b0100);

    // Elapsed-counter and summed-weight saturation
    phase = "saturation";
    wr_w(0, 'hC000); wr_w(1, 'hC000);
    do_arr(0); do_arr(1);
    set_idle();
    repeat (70000) step(0);
    do_arr(0);
    check("sat_delta", delta_t, 'hFFFF);
    check("sat_sum", sum_weight, 'hFFFF);

    // Backlog saturation and drain on flow 3
    phase = "backlog_sat";
    for (int i = 0; i < (1 << QW); i++) do_arr(3);
    for (int i = 0; i < QMAX; i++) do_dep(3);
    check("drained_f3", active_mask[3], 0);

    // Departure on an empty flow: flagged, not an event
    phase = "dep_empty";
    do_dep(3);
    check("dep_err_pulse", dep_err, 1);
    check("dep_err_no_start", start, 0);
    idle(1);
    check("dep_err_clears", dep_err, 0);
    idle(2);
    do_arr(3);
    check("after_dep_err_delta", delta_t, 5);

    // Random traffic
    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs(40, 45, 10);
      step(1);
    end
    set_idle();

    // Reset arriving together with an event
    phase = "reset_mid";
    arr_valid = 1; arr_flow = 2; rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    step(1);
    set_idle();
    rst = 1'b1;
    step(1);
    check("post_reset_start", start, 0);
    check("post_reset_mask", active_mask, 0);
    do_arr(1);
    check("post_reset_arr_start", start, 0);
    check("post_reset_arr_mask", active_mask, 'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
